// File: rtl/btn_matrix_scan.sv
// btn_matrix_scan: column scanner and frame debouncer for the 5x4 button matrix.
// Ports: clk, RSTN (sync, active-low), scan_en, BTN_X (column drive, active-low),
//        BTN_Y (row sense, active-low, async), key_state (debounced map, bit col*4+row),
//        key_valid (one-cycle press pulse), key_code (lowest new press index, held).
module btn_matrix_scan #(
    parameter int SCAN_DIV = 2000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        scan_en,
    output logic [4:0]  BTN_X,
    input  logic [3:0]  BTN_Y,
    output logic [19:0] key_state,
    output logic        key_valid,
    output logic [4:0]  key_code
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EVAL
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [2:0]    col_q, col_d;
    logic [DW-1:0] div_q, div_d;
    logic [19:0]   raw_q, raw_d;
    logic [19:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    btn_x_q, btn_x_d;
    logic [19:0]   key_state_q, key_state_d;
    logic          key_valid_q, key_valid_d;
    logic [4:0]    key_code_q, key_code_d;
    logic [19:0]   new_keys;
    logic [4:0]    low_idx;

    // Keys pressed in the current frame that are not yet in the committed map.
    always_comb begin
        new_keys = raw_q & ~key_state_q;
        low_idx  = '0;
        for (int k = 19; k >= 0; k--) begin
            if (new_keys[k]) begin
                low_idx = 5'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        div_d       = div_q;
        raw_d       = raw_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        btn_x_d     = 5'b11111;

        unique case (state_q)
            S_IDLE: begin
                col_d = '0;
                div_d = '0;
                cnt_d = '0;
                if (scan_en) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!scan_en) begin
                    // Abandon the partial frame; the debounce run restarts.
                    state_d = S_IDLE;
                    col_d   = '0;
                    div_d   = '0;
                    cnt_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    for (int c = 0; c < 5; c++) begin
                        if (col_q == 3'(c)) begin
                            raw_d[c*4 +: 4] = ~sync2_q;
                        end
                    end
                    div_d = '0;
                    if (col_q == 3'd4) begin
                        state_d = S_EVAL;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_EVAL: begin
                col_d  = '0;
                div_d  = '0;
                prev_d = raw_q;
                if (raw_q == prev_q) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
                // A completed run of identical frames that differs from the map.
                if (cnt_d == CNT_MAX && raw_q != key_state_q) begin
                    key_state_d = raw_q;
                    if (|new_keys) begin
                        key_valid_d = 1'b1;
                        key_code_d  = low_idx;
                    end
                end
                if (scan_en) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Column drive is registered from next state so it lines up with div=0.
        if (state_d == S_SCAN) begin
            btn_x_d = ~(5'b00001 << col_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            col_q       <= '0;
            div_q       <= '0;
            raw_q       <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            btn_x_q     <= 5'b11111;
            key_state_q <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= BTN_Y;
            sync2_q     <= sync1_q;
            col_q       <= col_d;
            div_q       <= div_d;
            raw_q       <= raw_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            btn_x_q     <= btn_x_d;
            key_state_q <= key_state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign BTN_X     = btn_x_q;
    assign key_state = key_state_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_btn_matrix_scan.sv
// tb_btn_matrix_scan: scoreboard bench for btn_matrix_scan with a matrix model
// and a frame-level debounce reference.
module tb_btn_matrix_scan;

    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 5 * SD + 1;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        scan_en = 1'b1;
    logic [4:0]  BTN_X;
    logic [3:0]  BTN_Y;
    logic [19:0] key_state;
    logic        key_valid;
    logic [4:0]  key_code;

    logic [19:0] pressed = '0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    typedef struct {
        int          cyc;
        logic [19:0] st;
        logic        v;
        logic [4:0]  code;
    } ev_t;

    ev_t         sb[$];
    logic [19:0] hist[$];
    logic [19:0] m_state;
    logic [4:0]  m_code;
    logic [19:0] last_ks = '0;
    ev_t         mon_e;

    btn_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .scan_en   (scan_en),
        .BTN_X     (BTN_X),
        .BTN_Y     (BTN_Y),
        .key_state (key_state),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pressed key (c,r) pulls row r low while column c is driven low.
    always_comb begin
        BTN_Y = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!BTN_X[c] && pressed[c*4+r]) begin
                    BTN_Y[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        m_state = '0;
        m_code  = '0;
    endtask

    task automatic model_restart();
        logic [19:0] last;
        last = hist[$];
        hist.delete();
        hist.push_back(last);
    endtask

    // A frame commits when the last DB frames are identical and differ from the map.
    task automatic model_frame(input logic [19:0] raw, input int when);
        logic        same;
        logic [19:0] nw;
        ev_t         e;
        hist.push_back(raw);
        while (hist.size() > DB) void'(hist.pop_front());
        same = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != raw) same = 1'b0;
        if (same && raw != m_state) begin
            nw      = raw & ~m_state;
            m_state = raw;
            e.v     = (nw != 0);
            if (e.v) begin
                for (int k = 19; k >= 0; k--) if (nw[k]) m_code = 5'(k);
            end
            e.cyc  = when;
            e.st   = m_state;
            e.code = m_code;
            sb.push_back(e);
        end
    endtask

    // Called #1 after a frame-start edge; returns #1 after the next one.
    task automatic run_frame(input logic [19:0] keys);
        int s;
        logic [4:0] ex;
        s       = cyc;
        pressed = keys;
        model_frame(keys, s + FRAME);
        for (int j = 0; j < FRAME; j++) begin
            ex = (j < 5 * SD) ? ~(5'b00001 << (j / SD)) : 5'b11111;
            chk("btn_x_seq", {27'd0, BTN_X}, {27'd0, ex});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_btn_x"}, {27'd0, BTN_X}, 32'h1f);
        chk({tag, "_key_state"}, {12'd0, key_state}, 32'h0);
        chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
        chk({tag, "_key_code"}, {27'd0, key_code}, 32'h0);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk_reset_outputs("reset");
        pressed = '0;
        model_reset();
        RSTN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (RSTN && (key_state != last_ks || key_valid)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_event key_state=%h key_valid=%b required=no_change",
                         key_state, key_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_state", {12'd0, key_state}, {12'd0, mon_e.st});
                chk("ev_valid", {31'd0, key_valid}, {31'd0, mon_e.v});
                chk("ev_code", {27'd0, key_code}, {27'd0, mon_e.code});
            end
        end
        last_ks = key_state;
    end

    localparam logic [19:0] K14 = 20'h04000;
    localparam logic [19:0] K7  = 20'h00080;
    localparam logic [19:0] K5  = 20'h00020;
    localparam logic [19:0] K9  = 20'h00200;
    localparam logic [19:0] K2  = 20'h00004;
    localparam logic [19:0] K3  = 20'h00008;

    initial begin
        logic [19:0] keys;
        int hold;
        int n;

        model_reset();
        do_reset();

        repeat (3) run_frame(K14);
        chk("k14_state", {12'd0, key_state}, {12'd0, K14});
        chk("k14_code", {27'd0, key_code}, 32'd14);
        repeat (3) run_frame('0);
        chk("k14_release", {12'd0, key_state}, 32'h0);

        repeat (5) begin
            run_frame(K7);
            run_frame('0);
        end
        chk("bounce_state", {12'd0, key_state}, 32'h0);

        repeat (3) run_frame(K5 | K9);
        chk("k5k9_state", {12'd0, key_state}, 32'h00220);
        chk("k5k9_code", {27'd0, key_code}, 32'd5);
        repeat (3) run_frame(K5 | K9 | K2);
        chk("k2_code", {27'd0, key_code}, 32'd2);

        repeat (3) run_frame('0);
        repeat (3) run_frame(K14);
        pressed = K14;
        repeat (2 * SD + 1) begin
            @(posedge clk);
            #1;
        end
        scan_en = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_btn_x", {27'd0, BTN_X}, 32'h1f);
        chk("drop_state", {12'd0, key_state}, {12'd0, K14});
        model_restart();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("idle_btn_x", {27'd0, BTN_X}, 32'h1f);
        scan_en = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) run_frame(K14);
        chk("restart_state", {12'd0, key_state}, {12'd0, K14});

        repeat (2) run_frame(K3);
        pressed = K3;
        repeat (FRAME - 1) begin
            @(posedge clk);
            #1;
        end
        RSTN = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("eval_reset");
        do_reset();

        for (int g = 0; g < 14; g++) begin
            keys = '0;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) keys[$urandom_range(0, 19)] = 1'b1;
            hold = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) begin
                repeat (hold) begin
                    run_frame(keys);
                    run_frame('0);
                end
            end else begin
                repeat (hold) run_frame(keys);
            end
        end
        repeat (3) run_frame('0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
